// File: rtl/cmp_pkg.sv
// Shared defaults, result flag indices and the result-slot state type
// for the round-robin comparator arbiter.
package cmp_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 4;

  // Bit positions of the comparator flags when packed into a 3-bit vector.
  localparam int RES_GT = 2;
  localparam int RES_EQ = 1;
  localparam int RES_LT = 0;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/cmp_rr_arbiter_cmp.sv
// Shared unsigned magnitude comparator; purely combinational.
module cmp_rr_arbiter_cmp #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_ls_b
);

  assign a_gt_b = (a > b);
  assign a_eq_b = (a == b);
  assign a_ls_b = (a < b);

endmodule

// File: rtl/cmp_rr_arbiter.sv
// Round-robin arbiter in front of one shared comparator; the granted operand
// pair is registered and its result is presented one cycle later.
module cmp_rr_arbiter
  import cmp_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic                   rsp_gt,
  output logic                   rsp_eq,
  output logic                   rsp_lt
);

  // Handshake: a transfer happens on any edge where valid and ready are both
  // high; ready never waits on valid being low, and a stalled slot drops all
  // ready bits until the consumer takes the held result.

  slot_state_e      slot_q, slot_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;

  logic [WIDTH-1:0] op_a [N_REQ];
  logic [WIDTH-1:0] op_b [N_REQ];
  logic [IDW-1:0]   gnt_id;
  logic [IDW-1:0]   cand_id;
  logic             gnt_found;
  logic             can_accept;
  logic             accept;
  logic [2:0]       flags;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign op_a[i] = req_a[i*WIDTH +: WIDTH];
    assign op_b[i] = req_b[i*WIDTH +: WIDTH];
  end

  // Search begins at the pointer and wraps; first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand_id   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_id = IDW'((32'(ptr_q) + 32'(k)) % 32'(N_REQ));
      if (!gnt_found && req_valid[cand_id]) begin
        gnt_found = 1'b1;
        gnt_id    = cand_id;
      end
    end
  end

  // A full slot can be refilled in the same cycle it drains.
  assign can_accept = !rst && ((slot_q == SLOT_EMPTY) || rsp_ready);
  assign accept     = can_accept && gnt_found;

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[gnt_id] = 1'b1;
    end
  end

  always_comb begin
    slot_d   = slot_q;
    ptr_d    = ptr_q;
    rsp_id_d = rsp_id_q;
    a_d      = a_q;
    b_d      = b_q;
    if (accept) begin
      slot_d   = SLOT_FULL;
      ptr_d    = (gnt_id == IDW'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
      rsp_id_d = gnt_id;
      a_d      = op_a[gnt_id];
      b_d      = op_b[gnt_id];
    end else if ((slot_q == SLOT_FULL) && rsp_ready) begin
      slot_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q   <= SLOT_EMPTY;
      ptr_q    <= '0;
      rsp_id_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      slot_q   <= slot_d;
      ptr_q    <= ptr_d;
      rsp_id_q <= rsp_id_d;
      a_q      <= a_d;
      b_q      <= b_d;
    end
  end

  cmp_rr_arbiter_cmp #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .a      (a_q),
    .b      (b_q),
    .a_gt_b (flags[RES_GT]),
    .a_eq_b (flags[RES_EQ]),
    .a_ls_b (flags[RES_LT])
  );

  assign rsp_valid = (slot_q == SLOT_FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_gt    = flags[RES_GT];
  assign rsp_eq    = flags[RES_EQ];
  assign rsp_lt    = flags[RES_LT];

endmodule
